// File: rtl/multi_timer.sv
// multi_timer: NUM_CH prescaled down-counting timers with snapshot, interrupts and a register bus.
// Define MULTI_TIMER_PWM_EN to add a per-channel COMPARE register and registered PWM output.
module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(NUM_CH)+2:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [NUM_CH-1:0]         irq_vec,
  output logic                      irq,
  output logic [NUM_CH-1:0]         pwm_out
);
  localparam logic [2:0] R_STATUS  = 3'd0;
  localparam logic [2:0] R_CONTROL = 3'd1;
  localparam logic [2:0] R_PERIOD  = 3'd2;
  localparam logic [2:0] R_SNAP    = 3'd3;
  localparam logic [2:0] R_COMPARE = 3'd4;

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  period   [NUM_CH];
  logic [CNT_W-1:0]  snap     [NUM_CH];
  logic [PRE_W-1:0]  pre_cnt  [NUM_CH];
  logic [PRE_W-1:0]  prescale [NUM_CH];
  logic [NUM_CH-1:0] to, run, ito, cont;
  logic [NUM_CH-1:0] wr_ch, tick, expire;
  logic [31:0]       ch_sel;
  logic [2:0]        reg_sel;
  logic [31:0]       rd_val;

  always_comb begin
    ch_sel  = 32'(address) >> 3;
    reg_sel = address[2:0];
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ch[c]  = chipselect && !write_n && (ch_sel == 32'(c));
      tick[c]   = run[c] && (pre_cnt[c] == prescale[c]);
      expire[c] = tick[c] && (cnt[c] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]      <= '0;
        period[c]   <= '0;
        snap[c]     <= '0;
        pre_cnt[c]  <= '0;
        prescale[c] <= '0;
      end
      to   <= '0;
      run  <= '0;
      ito  <= '0;
      cont <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        pre_cnt[c] <= (!run[c] || tick[c]) ? '0 : pre_cnt[c] + PRE_W'(1);
        // A PERIOD write forces a reload and halts the channel, overriding any tick.
        if (wr_ch[c] && reg_sel == R_PERIOD) begin
          period[c] <= writedata[CNT_W-1:0];
          cnt[c]    <= writedata[CNT_W-1:0];
          run[c]    <= 1'b0;
        end else begin
          if (tick[c]) begin
            if (expire[c]) begin
              cnt[c] <= period[c];
              if (!cont[c]) run[c] <= 1'b0;
            end else begin
              cnt[c] <= cnt[c] - CNT_W'(1);
            end
          end
          if (wr_ch[c] && reg_sel == R_CONTROL) begin
            ito[c]      <= writedata[0];
            cont[c]     <= writedata[1];
            prescale[c] <= writedata[8 +: PRE_W];
            if (writedata[3])      run[c] <= 1'b0;
            else if (writedata[2]) run[c] <= 1'b1;
          end
        end
        if (expire[c])                               to[c] <= 1'b1;
        else if (wr_ch[c] && reg_sel == R_STATUS)    to[c] <= 1'b0;
        if (wr_ch[c] && reg_sel == R_SNAP)           snap[c] <= cnt[c];
      end
    end
  end

`ifdef MULTI_TIMER_PWM_EN
  logic [CNT_W-1:0] compare [NUM_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) compare[c] <= '0;
      pwm_out <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ch[c] && reg_sel == R_COMPARE) compare[c] <= writedata[CNT_W-1:0];
        pwm_out[c] <= run[c] && (cnt[c] < compare[c]);
      end
    end
  end
`else
  assign pwm_out = '0;
`endif

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 32'(c)) begin
        case (reg_sel)
          R_STATUS:  rd_val = {30'b0, run[c], to[c]};
          R_CONTROL: rd_val = {16'b0, 8'(prescale[c]), 6'b0, cont[c], ito[c]};
          R_PERIOD:  rd_val = 32'(period[c]);
          R_SNAP:    rd_val = 32'(snap[c]);
`ifdef MULTI_TIMER_PWM_EN
          R_COMPARE: rd_val = 32'(compare[c]);
`endif
          default:   rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_val;
  end

  assign irq_vec = to & ito;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus randomized continuous-mode
// trials checked against an arithmetic model of tick/timeout timing.
module tb_multi_timer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  irq_vec;
  logic        irq;
  logic [3:0]  pwm_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  localparam int R_STATUS = 0, R_CONTROL = 1, R_PERIOD = 2, R_SNAP = 3, R_COMPARE = 4;

  multi_timer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] adr(input int c, input int r);
    return 5'(c * 8 + r);
  endfunction

  // All bus tasks start and end at a falling edge; e is the index of the rising edge that sampled the access.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, output int e);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    e = cyc;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] v, output int e);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    v = readdata; e = cyc;
    chipselect = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Continuous-mode reference: k edges after START, ticks occur every (s+1) edges;
  // the count walks p..0 and a timeout happens on every (p+1)-th tick.
  function automatic void model(input int k, input int p, input int s,
                                output int cnt_exp, output int to_exp);
    int n;
    n = k / (s + 1);
    cnt_exp = p - (n % (p + 1));
    to_exp  = (n >= p + 1) ? 1 : 0;
  endfunction

  initial begin
    int e, s0, w, r, c, p, s, d, k, cexp, texp, hi;
    logic [31:0] v;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_irq_vec", {28'b0, irq_vec}, 32'h0);
    chk("reset_pwm", {28'b0, pwm_out}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(adr(0, R_STATUS), v, e);  chk("reset_status", v, 32'h0);
    bus_read(adr(2, R_CONTROL), v, e); chk("reset_control", v, 32'h0);
    bus_read(adr(3, R_PERIOD), v, e);  chk("reset_period", v, 32'h0);

    // Randomized continuous-mode trials.
    for (int t = 0; t < 8; t++) begin
      c = int'($urandom_range(0, 3));
      p = (t == 0) ? 0 : int'($urandom_range(1, 20));
      s = int'($urandom_range(0, 5));
      d = int'($urandom_range(0, 60));
      bus_write(adr(c, R_STATUS), 32'h0, e);
      bus_write(adr(c, R_PERIOD), 32'(p), e);
      bus_write(adr(c, R_CONTROL), 32'((s << 8) | 7), s0);
      wait_edge(s0 + d);
      bus_write(adr(c, R_SNAP), 32'h0, w);
      model(w - 1 - s0, p, s, cexp, texp);
      bus_read(adr(c, R_SNAP), v, r);
      chk("rand_snap", v, 32'(cexp));
      bus_read(adr(c, R_STATUS), v, r);
      model(r - 1 - s0, p, s, cexp, texp);
      chk("rand_status", v, 32'(2 + texp));
      model(cyc - s0, p, s, cexp, texp);
      chk("rand_irq_vec", {28'b0, irq_vec}, (texp != 0) ? (32'h1 << c) : 32'h0);
      bus_write(adr(c, R_CONTROL), 32'h8, e);
      bus_write(adr(c, R_STATUS), 32'h0, e);
    end
    chk("rand_idle_irq", {31'b0, irq}, 32'h0);

    // One-shot, PERIOD=3, PRESCALE=0, ITO=0.
    bus_write(adr(0, R_PERIOD), 32'd3, e);
    bus_write(adr(0, R_CONTROL), 32'h4, s0);
    for (int j = 0; j < 4; j++) begin
      chk("oneshot_cnt", dut.cnt[0], 32'(3 - j));
      @(negedge clk);
    end
    bus_read(adr(0, R_STATUS), v, e);
    chk("oneshot_status", v, 32'h1);
    chk("oneshot_irq", {31'b0, irq}, 32'h0);

    // STATUS write colliding with a timeout leaves TO set.
    bus_write(adr(0, R_STATUS), 32'h0, e);
    bus_read(adr(0, R_STATUS), v, e);
    chk("status_clear", v, 32'h0);
    bus_write(adr(0, R_CONTROL), 32'h4, s0);
    wait_edge(s0 + 3);
    bus_write(adr(0, R_STATUS), 32'h0, e);
    bus_read(adr(0, R_STATUS), v, e);
    chk("to_priority", v, 32'h1);
    bus_write(adr(0, R_STATUS), 32'h0, e);

    // ch1: PERIOD=2, PRESCALE=4, CONT, ITO -> timeout every 15 cycles.
    bus_write(adr(1, R_PERIOD), 32'd2, e);
    bus_write(adr(1, R_CONTROL), 32'h0407, s0);
    bus_read(adr(1, R_CONTROL), v, e);
    chk("control_readback", v, 32'h0403);
    wait_edge(s0 + 14);
    chk("ch1_pre_to", {28'b0, irq_vec}, 32'h0);
    wait_edge(s0 + 15);
    chk("ch1_to1_vec", {28'b0, irq_vec}, 32'h2);
    chk("ch1_to1_irq", {31'b0, irq}, 32'h1);
    bus_write(adr(1, R_STATUS), 32'h0, e);
    chk("ch1_clr_irq", {31'b0, irq}, 32'h0);
    wait_edge(s0 + 29);
    chk("ch1_pre_to2", {28'b0, irq_vec}, 32'h0);
    wait_edge(s0 + 30);
    chk("ch1_to2_vec", {28'b0, irq_vec}, 32'h2);
    bus_write(adr(1, R_CONTROL), 32'h8, e);
    bus_write(adr(1, R_STATUS), 32'h0, e);

    // START+STOP together, then PERIOD write while running.
    bus_write(adr(2, R_PERIOD), 32'd5, e);
    bus_write(adr(2, R_CONTROL), 32'hC, e);
    bus_read(adr(2, R_STATUS), v, e);
    chk("start_stop", v, 32'h0);
    bus_write(adr(2, R_CONTROL), 32'h4, s0);
    bus_read(adr(2, R_STATUS), v, e);
    chk("ch2_running", v, 32'h2);
    bus_write(adr(2, R_PERIOD), 32'd7, e);
    chk("reload_cnt", dut.cnt[2], 32'd7);
    bus_read(adr(2, R_STATUS), v, e);
    chk("reload_run", v, 32'h0);
    chk("reload_hold", dut.cnt[2], 32'd7);

    // SNAP while running.
    bus_write(adr(3, R_PERIOD), 32'd20, e);
    bus_write(adr(3, R_CONTROL), 32'h6, s0);
    wait_edge(s0 + 5);
    bus_write(adr(3, R_SNAP), 32'h0, w);
    repeat (3) @(negedge clk);
    bus_read(adr(3, R_SNAP), v, e);
    chk("snap_value", v, 32'(20 - (w - 1 - s0)));
    bus_write(adr(3, R_CONTROL), 32'h8, e);

    // Unmapped registers.
    bus_write(adr(0, 5), 32'hFFFF_FFFF, e);
    bus_read(adr(0, 5), v, e); chk("reg5_zero", v, 32'h0);
    bus_read(adr(1, 7), v, e); chk("reg7_zero", v, 32'h0);

    // PWM / COMPARE.
    bus_write(adr(0, R_PERIOD), 32'd9, e);
    bus_write(adr(0, R_COMPARE), 32'd3, e);
    bus_write(adr(0, R_CONTROL), 32'h6, s0);
    wait_edge(s0 + 12);
    hi = 0;
    for (int j = 0; j < 20; j++) begin
      hi += int'(pwm_out[0]);
      @(negedge clk);
    end
    bus_read(adr(0, R_COMPARE), v, e);
`ifdef MULTI_TIMER_PWM_EN
    chk("pwm_duty", 32'(hi), 32'd6);
    chk("compare_read", v, 32'd3);
`else
    chk("pwm_off", 32'(hi), 32'd0);
    chk("compare_read", v, 32'd0);
`endif
    bus_write(adr(0, R_CONTROL), 32'h8, e);
    bus_write(adr(0, R_STATUS), 32'h0, e);

    // Reset mid-count aborts without a timeout.
    bus_write(adr(0, R_PERIOD), 32'd50, e);
    bus_write(adr(0, R_CONTROL), 32'h7, s0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_cnt", dut.cnt[0], 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(adr(0, R_STATUS), v, e); chk("rst_status", v, 32'h0);
    bus_read(adr(0, R_PERIOD), v, e); chk("rst_period", v, 32'h0);
    repeat (60) @(negedge clk);
    chk("rst_no_irq", {31'b0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
